// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus (CDB) arbiter and its snoopers.
// Contents: producer count and tag/data widths, the producer index enum,
// and the broadcast bundle seen by the reservation stations, ROB and
// rename ready-table.
package cdb_arbiter_pkg;

  localparam int CDB_NUM_REQ = 4;
  localparam int CDB_TAG_W   = 6;
  localparam int CDB_DATA_W  = 32;

  typedef enum logic [1:0] {
    CDB_ALU    = 2'd0,
    CDB_LOAD   = 2'd1,
    CDB_BRANCH = 2'd2,
    CDB_MULT   = 2'd3
  } cdb_src_e;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Round-robin one-hot picker.
// Ports:
//   req   - request vector
//   ptr   - index where the search starts (ascending, wraps N-1 -> 0)
//   grant - one-hot grant to the first requester found from ptr
//   idx   - binary index of the granted requester (0 when none)
//   any   - at least one request present
module rr_select #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      cand = IW'((int'(ptr) + off) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per result producer, round-robin selection
// of one full slot per cycle, registered broadcast onto the common data bus.
// Ports:
//   clk, rst_n            - core clock, async active-low reset
//   flush                 - discard all held results, block accepts/grants
//   req_valid/tag/data    - producer results (flattened per producer)
//   req_ready             - slot i can take a result this cycle
//   cdb_valid/tag/data    - registered broadcast
//   cdb_src               - producer index of the broadcast
//   perf_grant_cnt/perf_stall_cnt - saturating 32-bit per-producer counters,
//                           present only when CDB_ARB_PERF_EN is defined
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = CDB_NUM_REQ,
  parameter  int TAG_W   = CDB_TAG_W,
  parameter  int DATA_W  = CDB_DATA_W,
  localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]     perf_grant_cnt,
  output logic [NUM_REQ*32-1:0]     perf_stall_cnt
`endif
);

  logic [NUM_REQ-1:0]             full_q, full_d;
  logic [NUM_REQ-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] data_q, data_d;
  logic [SRC_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic                           cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]               cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]              cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]               cdb_src_q, cdb_src_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic [SRC_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [NUM_REQ-1:0] accept;

  // Flush masks every slot so nothing is granted in the flush cycle.
  assign elig = full_q & ~{NUM_REQ{flush}};

  rr_select #(.N(NUM_REQ)) u_rr_select (
    .req   (elig),
    .ptr   (rr_ptr_q),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // A slot being drained this cycle can take a new result at the same edge.
  assign req_ready = flush ? '0 : (~full_q | gnt);
  assign accept    = req_valid & req_ready;

  always_comb begin
    full_d = full_q;
    tag_d  = tag_q;
    data_d = data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (flush) begin
        full_d[i] = 1'b0;
      end else if (accept[i]) begin
        full_d[i] = 1'b1;
        tag_d[i]  = req_tag[i*TAG_W +: TAG_W];
        data_d[i] = req_data[i*DATA_W +: DATA_W];
      end else if (gnt[i]) begin
        full_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = gnt_any;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (gnt_any) begin
      rr_ptr_d   = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
      cdb_tag_d  = tag_q[gnt_idx];
      cdb_data_d = data_q[gnt_idx];
      cdb_src_d  = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      full_q      <= full_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

`ifdef CDB_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [NUM_REQ-1:0][31:0] stall_cnt_q, stall_cnt_d;

  // Counters survive flush; only reset clears them.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i] && (grant_cnt_q[i] != 32'hFFFF_FFFF))
        grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
      if (req_valid[i] && !req_ready[i] && (stall_cnt_q[i] != 32'hFFFF_FFFF))
        stall_cnt_d[i] = stall_cnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_grant_cnt = grant_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a per-cycle vector table covering single
// result latency, four-way contention, fairness, back-pressure and flush,
// followed by hand-written reset-mid-operation and performance-counter runs.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [3:0]  req_valid;
  logic [23:0] req_tag;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;
`ifdef CDB_ARB_PERF_EN
  logic [127:0] perf_grant_cnt;
  logic [127:0] perf_stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  cdb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic           flush;
    logic [3:0]     valid;
    logic [3:0][5:0] tag;
    logic [3:0]     ready;
    logic           cv;
    logic [5:0]     ctag;
    logic [1:0]     csrc;
  } vec_t;

  vec_t tbl[$];

  // Data carried with each tag; tag 0 means "never broadcast" (reset value).
  function automatic logic [31:0] dat(input logic [5:0] t);
    if (t == 6'd0) return 32'h0;
    if (t == 6'd5) return 32'h0000_1234;
    return {8'hA5, 18'h0, t};
  endfunction

  function automatic vec_t r(input logic f, input logic [3:0] v,
                             input int t0, input int t1, input int t2, input int t3,
                             input logic [3:0] rdy, input logic cv,
                             input int ct, input int cs);
    vec_t x;
    x.flush  = f;
    x.valid  = v;
    x.tag[0] = 6'(t0);
    x.tag[1] = 6'(t1);
    x.tag[2] = 6'(t2);
    x.tag[3] = 6'(t3);
    x.ready  = rdy;
    x.cv     = cv;
    x.ctag   = 6'(ct);
    x.csrc   = 2'(cs);
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic [3:0] v, input logic [3:0][5:0] t);
    flush     = f;
    req_valid = v;
    for (int i = 0; i < 4; i++) begin
      req_tag[i*6 +: 6]   = t[i];
      req_data[i*32 +: 32] = dat(t[i]);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [3:0][5:0] tz;
  logic [3:0][5:0] tt;

  initial begin
    tz = '0;
    rst_n = 1'b1;
    drive(1'b0, 4'b0, tz);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset cdb_valid", 64'(cdb_valid), 64'd0);
    chk("reset cdb_tag",   64'(cdb_tag),   64'd0);
    chk("reset cdb_data",  64'(cdb_data),  64'd0);
    chk("reset cdb_src",   64'(cdb_src),   64'd0);
    chk("reset req_ready", 64'(req_ready), 64'hF);
    #2 rst_n = 1'b1;

    // single ALU result
    tbl.push_back(r(0, 4'b0001,  5, 0, 0, 0, 4'b1111, 0,  0, 0));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 0,  0, 0));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 1,  5, 0));
    // multiply result moves rr_ptr back to 0
    tbl.push_back(r(0, 4'b1000,  0, 0, 0, 7, 4'b1111, 0,  5, 0));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 0,  5, 0));
    // all four producers at once
    tbl.push_back(r(0, 4'b1111,  1, 2, 3, 4, 4'b1111, 1,  7, 3));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b0001, 0,  7, 3));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b0011, 1,  1, 0));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b0111, 1,  2, 1));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 1,  3, 2));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 1,  4, 3));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 0,  4, 3));
    // fairness: ALU streaming, branch once -> grants 0,2,0,0
    tbl.push_back(r(0, 4'b0101, 10, 0,20, 0, 4'b1111, 0,  4, 3));
    tbl.push_back(r(0, 4'b0001, 10, 0, 0, 0, 4'b1011, 0,  4, 3));
    tbl.push_back(r(0, 4'b0001, 10, 0, 0, 0, 4'b1110, 1, 10, 0));
    tbl.push_back(r(0, 4'b0001, 10, 0, 0, 0, 4'b1111, 1, 20, 2));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 1, 10, 0));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 1, 10, 0));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 0, 10, 0));
    // steer rr_ptr to 2 via a load grant
    tbl.push_back(r(0, 4'b0010,  0, 8, 0, 0, 4'b1111, 0, 10, 0));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 0, 10, 0));
    // back-pressure on the load slot while it waits behind 3 and 0
    tbl.push_back(r(0, 4'b1011, 13,14, 0,15, 4'b1111, 1,  8, 1));
    tbl.push_back(r(0, 4'b0010,  0, 9, 0, 0, 4'b1100, 0,  8, 1));
    tbl.push_back(r(0, 4'b0010,  0, 9, 0, 0, 4'b1101, 1, 15, 3));
    tbl.push_back(r(0, 4'b0010,  0, 9, 0, 0, 4'b1111, 1, 13, 0));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 1, 14, 1));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 1,  9, 1));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 0,  9, 1));
    // flush with three slots full and a broadcast in flight
    tbl.push_back(r(0, 4'b1111, 21,22,23,24, 4'b1111, 0,  9, 1));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b0100, 0,  9, 1));
    tbl.push_back(r(1, 4'b1111, 31,32,33,34, 4'b0000, 1, 23, 2));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 0, 23, 2));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 0, 23, 2));
    tbl.push_back(r(0, 4'b0000,  0, 0, 0, 0, 4'b1111, 0, 23, 2));

    foreach (tbl[k]) begin
      tick();
      drive(tbl[k].flush, tbl[k].valid, tbl[k].tag);
      @(negedge clk);
      chk($sformatf("row%0d req_ready", k), 64'(req_ready), 64'(tbl[k].ready));
      chk($sformatf("row%0d cdb_valid", k), 64'(cdb_valid), 64'(tbl[k].cv));
      chk($sformatf("row%0d cdb_tag", k),   64'(cdb_tag),   64'(tbl[k].ctag));
      chk($sformatf("row%0d cdb_data", k),  64'(cdb_data),  64'(dat(tbl[k].ctag)));
      chk($sformatf("row%0d cdb_src", k),   64'(cdb_src),   64'(tbl[k].csrc));
    end

    // reset asserted while a broadcast is on the bus and slots are full
    tt[0] = 6'd40; tt[1] = 6'd41; tt[2] = 6'd42; tt[3] = 6'd43;
    tick(); drive(1'b0, 4'b1111, tt);
    tick(); drive(1'b0, 4'b0000, tz);
    tick();
    chk("pre-reset cdb_valid", 64'(cdb_valid), 64'd1);
    chk("pre-reset cdb_tag",   64'(cdb_tag),   64'd43);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset cdb_valid", 64'(cdb_valid), 64'd0);
    chk("async reset cdb_tag",   64'(cdb_tag),   64'd0);
    chk("async reset cdb_data",  64'(cdb_data),  64'd0);
    chk("async reset cdb_src",   64'(cdb_src),   64'd0);
    chk("async reset req_ready", 64'(req_ready), 64'hF);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("post-reset idle%0d cdb_valid", c), 64'(cdb_valid), 64'd0);
    end

    // load unit: 9 streamed grants, then contention gives 3 stalls and a 10th grant
    tt = tz;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (c == 10) begin
        tt[0] = 6'd51; tt[1] = 6'd50; tt[2] = 6'd52; tt[3] = 6'd53;
        drive(1'b0, 4'b1111, tt);
      end else begin
        tt = tz;
        tt[1] = 6'd50;
        drive(1'b0, {2'b00, ((c <= 8) || (c >= 11 && c <= 13)), 1'b0}, tt);
      end
      #1;
      if (c <= 8 || c == 10 || c == 14)
        chk($sformatf("perf c%0d ready1", c), 64'(req_ready[1]), 64'd1);
      if (c >= 11 && c <= 13)
        chk($sformatf("perf c%0d ready1 stall", c), 64'(req_ready[1]), 64'd0);
    end
    drive(1'b0, 4'b0000, tz);
    tick();
    tick();
    @(negedge clk);
`ifdef CDB_ARB_PERF_EN
    chk("perf grant1", 64'(perf_grant_cnt[63:32]),  64'd10);
    chk("perf stall1", 64'(perf_stall_cnt[63:32]),  64'd3);
    chk("perf grant0", 64'(perf_grant_cnt[31:0]),   64'd1);
    chk("perf grant2", 64'(perf_grant_cnt[95:64]),  64'd1);
    chk("perf grant3", 64'(perf_grant_cnt[127:96]), 64'd1);
    chk("perf stall0", 64'(perf_stall_cnt[31:0]),   64'd0);
`endif
    tick(); drive(1'b1, 4'b0000, tz);
    tick(); drive(1'b0, 4'b0000, tz);
    @(negedge clk);
    chk("after flush cdb_valid", 64'(cdb_valid), 64'd0);
    chk("after flush req_ready", 64'(req_ready), 64'hF);
`ifdef CDB_ARB_PERF_EN
    chk("flush keeps grant1", 64'(perf_grant_cnt[63:32]), 64'd10);
    chk("flush keeps stall1", 64'(perf_stall_cnt[63:32]), 64'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
